// File: rtl/ita_package.sv
// Shared types for the ITA step scheduler: step codes, head width,
// latched layer configuration and scheduler FSM states.
package ita_package;

  localparam int unsigned H     = 4;
  localparam int unsigned HeadW = $clog2(H + 1);
  localparam int unsigned TileW = 32;

  typedef logic [HeadW-1:0] n_heads_t;

  typedef enum logic [2:0] {
    StepIdle,
    StepQ,
    StepK,
    StepV,
    StepQK,
    StepAV,
    StepOW
  } step_e;

  typedef struct packed {
    n_heads_t         n_heads;
    logic [TileW-1:0] lin_tiles;
    logic [TileW-1:0] attn_tiles;
  } ctrl_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    FINISH
  } sched_state_e;

  // A zero tile count behaves like a single tile.
  function automatic logic [TileW-1:0] last_idx(
    input logic [TileW-1:0] n
  );
    return (n == '0) ? '0 : n - 1'b1;
  endfunction

endpackage

// File: rtl/ita_step_counter.sv
// Tile/step/head iteration for one layer; advances on en_i and
// flags the final tile of OW on the final head.
module ita_step_counter
  import ita_package::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic        en_i,
  input  ctrl_t       ctrl_i,
  output step_e       step_o,
  output n_heads_t    head_o,
  output logic [31:0] tile_o,
  output logic        last_o
);

  step_e       step_q, step_d;
  n_heads_t    head_q, head_d;
  logic [31:0] tile_q, tile_d;

  logic        lin_step;
  logic [31:0] tile_max;
  logic        last_tile;
  logic        last_head;

  always_comb begin
    lin_step  = (step_q == StepQ) || (step_q == StepK) ||
                (step_q == StepV) || (step_q == StepOW);
    tile_max  = last_idx(lin_step ? ctrl_i.lin_tiles
                                  : ctrl_i.attn_tiles);
    last_tile = (tile_q == tile_max);
    last_head = (head_q == n_heads_t'(ctrl_i.n_heads - 1'b1));
    last_o    = last_tile && (step_q == StepOW) && last_head;
  end

  always_comb begin
    step_d = step_q;
    head_d = head_q;
    tile_d = tile_q;
    if (clear_i) begin
      step_d = StepQ;
      head_d = '0;
      tile_d = '0;
    end else if (en_i) begin
      if (!last_tile) begin
        tile_d = tile_q + 1'b1;
      end else begin
        tile_d = '0;
        case (step_q)
          StepQ:   step_d = StepK;
          StepK:   step_d = StepV;
          StepV:   step_d = StepQK;
          StepQK:  step_d = StepAV;
          StepAV:  step_d = StepOW;
          StepOW: begin
            step_d = StepQ;
            head_d = head_q + 1'b1;
          end
          default: step_d = StepQ;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      step_q <= StepQ;
      head_q <= '0;
      tile_q <= '0;
    end else begin
      step_q <= step_d;
      head_q <= head_d;
      tile_q <= tile_d;
    end
  end

  assign step_o = step_q;
  assign head_o = head_q;
  assign tile_o = tile_q;

endmodule

// File: rtl/ita_step_scheduler.sv
// Per-layer attention tile scheduler, one outstanding tile at a time.
// Optional busy-cycle counter: define ITA_SCHED_PERF_CNT_EN.
module ita_step_scheduler
  import ita_package::*;
#(
  parameter int unsigned H = ita_package::H
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic        start_i,
  input  n_heads_t    n_heads_i,
  input  logic [31:0] lin_tiles_i,
  input  logic [31:0] attn_tiles_i,
  output logic        issue_valid_o,
  input  logic        issue_ready_i,
  output step_e       step_o,
  output n_heads_t    head_o,
  output logic [31:0] tile_o,
  input  logic        tile_done_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] cycles_o
);

  sched_state_e state_q, state_d;
  ctrl_t        ctrl_q, ctrl_d;

  logic        cnt_clear;
  logic        cnt_en;
  step_e       c_step;
  n_heads_t    c_head;
  logic [31:0] c_tile;
  logic        c_last;
  n_heads_t    nh_clamp;

  // Requests above the head capacity run at full capacity.
  assign nh_clamp = (n_heads_i > n_heads_t'(H)) ? n_heads_t'(H)
                                                : n_heads_i;

  ita_step_counter u_cnt (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (cnt_clear),
    .en_i    (cnt_en),
    .ctrl_i  (ctrl_q),
    .step_o  (c_step),
    .head_o  (c_head),
    .tile_o  (c_tile),
    .last_o  (c_last)
  );

  always_comb begin
    state_d       = state_q;
    ctrl_d        = ctrl_q;
    cnt_clear     = 1'b0;
    cnt_en        = 1'b0;
    issue_valid_o = 1'b0;
    busy_o        = 1'b0;
    done_o        = 1'b0;
    step_o        = StepIdle;
    head_o        = c_head;
    tile_o        = c_tile;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          ctrl_d.n_heads    = nh_clamp;
          ctrl_d.lin_tiles  = lin_tiles_i;
          ctrl_d.attn_tiles = attn_tiles_i;
          cnt_clear         = 1'b1;
          state_d = (nh_clamp == '0) ? FINISH : ISSUE;
        end
      end
      ISSUE: begin
        issue_valid_o = 1'b1;
        busy_o        = 1'b1;
        step_o        = c_step;
        if (issue_ready_i) state_d = WAIT;
      end
      WAIT: begin
        busy_o = 1'b1;
        step_o = c_step;
        if (tile_done_i) begin
          if (c_last) begin
            cnt_clear = 1'b1;
            state_d   = FINISH;
          end else begin
            cnt_en  = 1'b1;
            state_d = ISSUE;
          end
        end
      end
      FINISH: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Abort beats every other event, including the done pulse.
    if (clear_i) begin
      state_d   = IDLE;
      ctrl_d    = ctrl_q;
      cnt_clear = 1'b1;
      cnt_en    = 1'b0;
      done_o    = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
    end
  end

`ifdef ITA_SCHED_PERF_CNT_EN
  logic        start_acc;
  logic [31:0] cycles_q, cycles_d;

  assign start_acc = (state_q == IDLE) && start_i && !clear_i;

  always_comb begin
    cycles_d = cycles_q;
    if (start_acc) begin
      cycles_d = '0;
    end else if (busy_o && (cycles_q != '1)) begin
      cycles_d = cycles_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cycles_q <= '0;
    end else begin
      cycles_q <= cycles_d;
    end
  end

  assign cycles_o = cycles_q;
`else
  assign cycles_o = '0;
`endif

endmodule

// File: tb/tb_ita_step_scheduler.sv
// Scoreboard bench for ita_step_scheduler: expected commands queued
// per layer and popped on each issue handshake.
module tb_ita_step_scheduler;
  import ita_package::*;

  typedef struct packed {
    step_e       step;
    n_heads_t    head;
    logic [31:0] tile;
  } cmd_t;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        clear_i = 1'b0;
  logic        start_i = 1'b0;
  n_heads_t    n_heads_i = '0;
  logic [31:0] lin_tiles_i = '0;
  logic [31:0] attn_tiles_i = '0;
  logic        issue_valid_o;
  logic        issue_ready_i = 1'b0;
  step_e       step_o;
  n_heads_t    head_o;
  logic [31:0] tile_o;
  logic        tile_done_i = 1'b0;
  logic        busy_o;
  logic        done_o;
  logic [31:0] cycles_o;

  int   n_tests = 0;
  int   n_fail = 0;
  cmd_t exp_q[$];

  always #5 clk_i = ~clk_i;

  ita_step_scheduler dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .clear_i       (clear_i),
    .start_i       (start_i),
    .n_heads_i     (n_heads_i),
    .lin_tiles_i   (lin_tiles_i),
    .attn_tiles_i  (attn_tiles_i),
    .issue_valid_o (issue_valid_o),
    .issue_ready_i (issue_ready_i),
    .step_o        (step_o),
    .head_o        (head_o),
    .tile_o        (tile_o),
    .tile_done_i   (tile_done_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .cycles_o      (cycles_o)
  );

  function automatic void push_layer(int nh, int lin, int attn);
    step_e seq [6];
    cmd_t  c;
    int    cnt;
    seq = '{StepQ, StepK, StepV, StepQK, StepAV, StepOW};
    for (int h = 0; h < nh; h++) begin
      for (int s = 0; s < 6; s++) begin
        cnt = (seq[s] == StepQK || seq[s] == StepAV) ? attn : lin;
        if (cnt == 0) cnt = 1;
        for (int t = 0; t < cnt; t++) begin
          c.step = seq[s];
          c.head = n_heads_t'(h);
          c.tile = 32'(t);
          exp_q.push_back(c);
        end
      end
    end
  endfunction

  // Acts as the datapath: accepts after `stall` valid cycles and
  // returns tile_done one cycle after each handshake.
  task automatic run_layer(
    input  int nh, input int lin, input int attn,
    input  int stall, input int abort_at,
    output int ncmd, output int ndone,
    output int nbusy, output int dcyc,
    output logic [31:0] cyc_done
  );
    int   waitc = 0;
    bit   pend = 0;
    bit   fin = 0;
    cmd_t got, held, exp;
    ncmd = 0; ndone = 0; nbusy = 0; dcyc = -1;
    cyc_done = '0;
    held = '0;
    exp_q.delete();
    push_layer(nh, lin, attn);
    @(negedge clk_i);
    n_heads_i    = n_heads_t'(nh);
    lin_tiles_i  = 32'(lin);
    attn_tiles_i = 32'(attn);
    start_i      = 1'b1;
    @(negedge clk_i);
    start_i      = 1'b0;
    n_heads_i    = n_heads_t'(nh + 1);
    lin_tiles_i  = 32'(lin + 5);
    attn_tiles_i = 32'(attn + 7);
    for (int cyc = 0; cyc < 2000 && !fin; cyc++) begin
      if (cyc > 0) @(negedge clk_i);
      issue_ready_i = 1'b0;
      tile_done_i   = 1'b0;
      clear_i       = 1'b0;
      if (busy_o) nbusy++;
      got.step = step_o;
      got.head = head_o;
      got.tile = tile_o;
      if (done_o) begin
        ndone++;
        dcyc     = cyc;
        cyc_done = cycles_o;
        fin      = 1;
      end else if (issue_valid_o) begin
        if (waitc == 0) begin
          held = got;
        end else begin
          n_tests++;
          if (got !== held) begin
            n_fail++;
            $display("FAIL stable: got %h held %h", got, held);
          end
        end
        if (waitc < stall) begin
          waitc++;
        end else begin
          waitc = 0;
          issue_ready_i = 1'b1;
          n_tests++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL extra_cmd: got %h expected none", got);
          end else begin
            exp = exp_q.pop_front();
            if (got !== exp) begin
              n_fail++;
              $display("FAIL cmd%0d: got %h expected %h",
                       ncmd, got, exp);
            end
          end
          ncmd++;
          pend = 1;
        end
      end else if (waitc > 0) begin
        n_tests++; n_fail++;
        $display("FAIL valid_drop: valid 0 expected 1");
        waitc = 0;
      end else if (pend) begin
        pend = 0;
        tile_done_i = 1'b1;
        if (ncmd == abort_at) begin
          clear_i = 1'b1;
          @(negedge clk_i);
          clear_i     = 1'b0;
          tile_done_i = 1'b0;
          n_tests++;
          if (busy_o !== 1'b0 || issue_valid_o !== 1'b0 ||
              step_o !== StepIdle || done_o !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_idle: busy %b valid %b step %0d done %b expected 0 0 0 0",
                     busy_o, issue_valid_o, step_o, done_o);
          end
          exp_q.delete();
          fin = 1;
        end
      end
    end
    if (!fin) begin
      n_tests++; n_fail++;
      $display("FAIL timeout: layer nh=%0d not finished", nh);
    end
    if (abort_at < 0) begin
      n_tests++;
      if (exp_q.size() != 0) begin
        n_fail++;
        $display("FAIL missing_cmds: %0d left expected 0",
                 exp_q.size());
      end
      @(negedge clk_i);
      n_tests++;
      if (done_o !== 1'b0 || busy_o !== 1'b0) begin
        n_fail++;
        $display("FAIL after_done: done %b busy %b expected 0 0",
                 done_o, busy_o);
      end
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (3) @(negedge clk_i);
    n_tests++;
    if (issue_valid_o !== 1'b0 || busy_o !== 1'b0 ||
        done_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctl: valid %b busy %b done %b expected 0",
               issue_valid_o, busy_o, done_o);
    end
    n_tests++;
    if (step_o !== StepIdle || head_o !== '0 || tile_o !== '0) begin
      n_fail++;
      $display("FAIL reset_fields: step %0d head %0d tile %0d expected 0",
               step_o, head_o, tile_o);
    end
    n_tests++;
    if (cycles_o !== '0) begin
      n_fail++;
      $display("FAIL reset_cycles: got %0d expected 0", cycles_o);
    end
    rst_ni = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic test_order();
    int nc, nd, nb, dc;
    logic [31:0] cy;
    run_layer(1, 2, 1, 0, -1, nc, nd, nb, dc, cy);
    n_tests++;
    if (nc != 10 || nd != 1) begin
      n_fail++;
      $display("FAIL order_counts: cmds %0d dones %0d expected 10 1",
               nc, nd);
    end
  endtask

  task automatic test_heads();
    int nc, nd, nb, dc;
    logic [31:0] cy;
    run_layer(2, 1, 1, 0, -1, nc, nd, nb, dc, cy);
    n_tests++;
    if (nc != 12 || nd != 1) begin
      n_fail++;
      $display("FAIL heads_counts: cmds %0d dones %0d expected 12 1",
               nc, nd);
    end
  endtask

  task automatic test_stall();
    int nc, nd, nb, dc;
    logic [31:0] cy;
    run_layer(1, 1, 2, 5, -1, nc, nd, nb, dc, cy);
    n_tests++;
    if (nc != 8 || nd != 1) begin
      n_fail++;
      $display("FAIL stall_counts: cmds %0d dones %0d expected 8 1",
               nc, nd);
    end
  endtask

  task automatic test_zero();
    int nc, nd, nb, dc;
    logic [31:0] cy;
    run_layer(0, 3, 3, 0, -1, nc, nd, nb, dc, cy);
    n_tests++;
    if (nc != 0 || nd != 1 || dc != 0) begin
      n_fail++;
      $display("FAIL zero_heads: cmds %0d dones %0d at %0d expected 0 1 0",
               nc, nd, dc);
    end
    run_layer(1, 0, 2, 0, -1, nc, nd, nb, dc, cy);
    n_tests++;
    if (nc != 8) begin
      n_fail++;
      $display("FAIL zero_lin: cmds %0d expected 8", nc);
    end
    run_layer(1, 3, 0, 0, -1, nc, nd, nb, dc, cy);
    n_tests++;
    if (nc != 14) begin
      n_fail++;
      $display("FAIL zero_attn: cmds %0d expected 14", nc);
    end
  endtask

  task automatic test_clear();
    int nc, nd, nb, dc;
    logic [31:0] cy;
    int seen = 0;
    run_layer(1, 2, 1, 0, 4, nc, nd, nb, dc, cy);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      if (done_o || busy_o) seen++;
    end
    n_tests++;
    if (nd != 0 || seen != 0 || nc != 4) begin
      n_fail++;
      $display("FAIL clear: dones %0d late %0d cmds %0d expected 0 0 4",
               nd, seen, nc);
    end
    run_layer(1, 1, 1, 0, -1, nc, nd, nb, dc, cy);
    n_tests++;
    if (nc != 6 || nd != 1) begin
      n_fail++;
      $display("FAIL restart: cmds %0d dones %0d expected 6 1",
               nc, nd);
    end
  endtask

  task automatic test_perf();
    int nc, nd, nb, dc;
    logic [31:0] cy;
`ifdef ITA_SCHED_PERF_CNT_EN
    run_layer(1, 2, 1, 2, -1, nc, nd, nb, dc, cy);
    n_tests++;
    if (cy !== 32'(nb)) begin
      n_fail++;
      $display("FAIL perf_first: cycles %0d expected %0d", cy, nb);
    end
    run_layer(1, 1, 1, 0, -1, nc, nd, nb, dc, cy);
    n_tests++;
    if (cy !== 32'(nb)) begin
      n_fail++;
      $display("FAIL perf_second: cycles %0d expected %0d", cy, nb);
    end
`else
    run_layer(1, 2, 1, 2, -1, nc, nd, nb, dc, cy);
    n_tests++;
    if (cy !== '0 || cycles_o !== '0 || nb == 0) begin
      n_fail++;
      $display("FAIL perf_off: cycles %0d now %0d busy %0d expected 0 0 >0",
               cy, cycles_o, nb);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_order();
    test_heads();
    test_stall();
    test_zero();
    test_clear();
    test_perf();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
